// File: rtl/block_responder_pkg.sv
// Shared definitions for the block-side responder: channel state encoding
// and default sizing constants.
package block_responder_pkg;

    localparam int unsigned N_CH        = 7;
    localparam int unsigned LAT_W       = 8;
    localparam int unsigned DEFAULT_LAT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ch_state_e;

endpackage

// File: rtl/block_channel.sv
// One responder channel: start/latency/done FSM with its own latency
// register, countdown and sticky abort flag.
module block_channel #(
    parameter int unsigned LAT_W       = block_responder_pkg::LAT_W,
    parameter int unsigned DEFAULT_LAT = block_responder_pkg::DEFAULT_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             lat_we,
    input  logic [LAT_W-1:0] lat_in,
    input  logic             abort_clr,
    output logic             done,
    output logic             busy,
    output logic             abort_flag
);
    import block_responder_pkg::*;

    ch_state_e        state, state_nxt;
    logic [LAT_W-1:0] cnt;
    logic [LAT_W-1:0] lat;
    logic             abort_set;
    logic             done_d, busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Withdrawal while BUSY wins over the cnt==0 completion.
    always_comb begin
        state_nxt = state;
        abort_set = 1'b0;
        unique case (state)
            IDLE: if (req) state_nxt = BUSY;
            BUSY: begin
                if (!req) begin
                    state_nxt = IDLE;
                    abort_set = 1'b1;
                end else if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    if (!req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status bits are decoded from the next state and flopped, so they
    // change glitch-free on the same edge as the state register.
    always_comb begin
        done_d = (state_nxt == DONE);
        busy_d = (state_nxt == BUSY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            done <= done_d;
            busy <= busy_d;
        end
    end

    // A start samples lat before any same-cycle write lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == IDLE && req) begin
            cnt <= lat;
        end else if (state == BUSY && req && cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat <= LAT_W'(DEFAULT_LAT);
        end else if (lat_we) begin
            lat <= lat_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abort_flag <= 1'b0;
        end else if (abort_set) begin
            abort_flag <= 1'b1;
        end else if (abort_clr) begin
            abort_flag <= 1'b0;
        end
    end

endmodule

// File: rtl/block_responder.sv
// Block-side partner of the 7-bit control/status handshake: one
// independent latency-emulating channel per control bit.
module block_responder #(
    parameter int unsigned N_CH        = block_responder_pkg::N_CH,
    parameter int unsigned LAT_W       = block_responder_pkg::LAT_W,
    parameter int unsigned DEFAULT_LAT = block_responder_pkg::DEFAULT_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  control,
    output logic [N_CH-1:0]  blocks,
    output logic [N_CH-1:0]  busy,
    output logic [N_CH-1:0]  abort_flags,
    input  logic [N_CH-1:0]  abort_clr,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_idx,
    input  logic [LAT_W-1:0] cfg_lat
);
    import block_responder_pkg::*;

    logic [N_CH-1:0] lat_we;

    // Out-of-range indices match no channel and are dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign lat_we[i] = cfg_we && (int'(cfg_idx) == i);

        block_channel #(
            .LAT_W       (LAT_W),
            .DEFAULT_LAT (DEFAULT_LAT)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .req        (control[i]),
            .lat_we     (lat_we[i]),
            .lat_in     (cfg_lat),
            .abort_clr  (abort_clr[i]),
            .done       (blocks[i]),
            .busy       (busy[i]),
            .abort_flag (abort_flags[i])
        );
    end

endmodule

// File: doc/block_responder.md
Name: block_responder

Overview:
- Block-side counterpart of the 7-bit control/status handshake.
- Receives the 7-bit control vector driven by the sequencing FSM. For each channel it emulates or wraps a processing block: it accepts a start, runs for a programmable latency, and then raises that channel's bit in the 7-bit blocks status vector returned to the FSM.
- Used in integration as the FSM's partner. Also used as the timing shell around real processing blocks.

Parameters:
- N_CH, 7, number of channels; matches the control/blocks width.
- LAT_W, 8, width of each per-channel latency register.
- DEFAULT_LAT, 4, latency value loaded into every channel on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- control  input  N_CH  per-channel request from the FSM; level-sensitive.
- blocks  output  N_CH  per-channel done/status back to the FSM; registered.
- busy  output  N_CH  per-channel busy status; registered.
- abort_flags  output  N_CH  sticky flag set when a request is withdrawn while busy.
- abort_clr  input  N_CH  per-bit clear for abort_flags.
- cfg_we  input  1  latency write strobe.
- cfg_idx  input  3  channel index for the write; 0..N_CH-1 valid.
- cfg_lat  input  LAT_W  latency value to write.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- On reset, all channels go to IDLE and every counter is 0. blocks=0, busy=0, abort_flags=0, and all latency registers are set to DEFAULT_LAT.
- Channels are independent. Each is a 3-state FSM:
  - IDLE: if control[i]=1 at a clock edge, go to BUSY and load cnt=lat[i].
  - BUSY, control[i]=1: if cnt!=0, decrement cnt; if cnt==0, go to DONE.
  - BUSY, control[i]=0 (abort): go to IDLE and set abort_flags[i]=1. The abort takes precedence over the cnt==0 completion.
  - DONE: hold while control[i]=1. When control[i]=0, go to IDLE.
- Outputs are registered from state: blocks[i]=(state==DONE), busy[i]=(state==BUSY).
- Latency: if control[i] is first sampled high at edge t, busy[i] rises after edge t and blocks[i] rises after edge t+lat+1. With lat=0, blocks rises one cycle after busy.
- Return to zero: blocks[i] falls one cycle after control[i] is sampled low. A new start requires control[i] to be seen low in IDLE first. Holding control high after DONE never restarts the channel.
- Config writes:
  - When cfg_we=1 and cfg_idx<N_CH, lat[cfg_idx]<=cfg_lat. Writes with cfg_idx>=N_CH are ignored.
  - A write to a BUSY channel does not affect the running cnt. The new value applies at the next start.
  - A write in the same cycle as a start is not used: the start loads the old lat.
- abort_flags:
  - Set has priority over abort_clr[i] in the same cycle.
  - abort_clr only clears the flag; it never changes channel state.
- Reset asserted mid-operation immediately forces the reset values, regardless of clk.
- No arithmetic wrap: cnt decrements only while non-zero.

Decomposition:
- Shared package holds:
  - the channel state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - constants N_CH=7 and DEFAULT_LAT.
- Sub-module block_channel holds one channel: FSM, counter, latency register and abort flag. It is instantiated N_CH times via generate.
- The top level does cfg_idx decode and vector assembly.

Test Plan:
- Reset check: assert reset mid-run with channel 2 BUSY -> blocks=0, busy=0 and abort_flags=0 immediately; all lat=4 afterward.
- Default latency: control=7'b0000001 from edge t -> busy[0]=1 after t; blocks[0]=1 after t+5. Drop control[0] -> blocks[0]=0 one cycle later.
- Programmed latency and zero latency:
  - Write cfg_idx=3, cfg_lat=0, then start channel 3 -> blocks[3] high 1 cycle after busy[3].
  - Write cfg_idx=7 -> no channel changes.
- Abort: start channel 5 with lat=10; drop control[5] after 3 cycles -> busy[5]=0, blocks[5] never rises, abort_flags[5]=1. Pulse abort_clr[5] -> flag clears. Set and clear in the same cycle -> flag stays 1.
- Concurrency and hold: start all 7 channels with lat=i -> blocks bits rise in order 0..6. Hold control=7'h7F for 20 cycles -> no restart. A mid-busy cfg write to channel 6 does not alter its completion time.
